mult_booth_seq: RTL and testbench



---
 rtl/mult_booth_seq_pkg.sv | 15 +
 rtl/mult_booth_seq_if.sv | 13 +
 rtl/mult_booth_seq_booth_step.sv | 19 +
 rtl/mult_booth_seq.sv | 67 ++++++
 tb/tb_mult_booth_seq.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/mult_booth_seq_pkg.sv
// mult_pkg: shared FSM states, Booth op encoding and extended-width helper (honours MULT_BOOTH_UNSIGNED_EN)
package mult_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_t;
   function automatic int ext_width(input int width);
`ifdef MULT_BOOTH_UNSIGNED_EN
      return width + 1;
`else
      return width;
`endif
   endfunction
   function automatic booth_op_t booth_op(input logic [1:0] pair);
      return pair == 2'b01 ? ADD : pair == 2'b10 ? SUB : NOP;
   endfunction
endpackage

// File: rtl/mult_booth_seq_if.sv
// mult_booth_seq_if: start/busy/done handshake and operand/product bus of the Booth multiplier
interface mult_booth_seq_if #(parameter int WIDTH = 32);
   logic             start;
   logic             is_unsigned;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   modport master (output start, is_unsigned, a, b, input busy, done, hi, lo);
   modport slave (input start, is_unsigned, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_booth_seq_booth_step.sv
// booth_step: one combinational radix-2 Booth add/subtract plus arithmetic right shift of the accumulator
module booth_step
   import mult_pkg::*;
#(
   parameter int E = 33
) (
   input  logic [2*E:0] p,
   input  logic [E-1:0] m,
   output logic [2*E:0] p_next
);
   booth_op_t op;
   logic [E:0] up, mx, sum;
   assign op = booth_op(p[1:0]);
   assign up = {p[2*E], p[2*E:E+1]};
   assign mx = {m[E-1], m};
   // one guard bit keeps the sum exact, so the bit shifted in is the true sign even when E bits overflow
   assign sum = op == ADD ? up + mx : op == SUB ? up - mx : up;
   assign p_next = {sum, p[E:1]};
endmodule

// File: rtl/mult_booth_seq.sv
// mult_booth_seq: sequential radix-2 Booth multiplier with HI/LO product, one step per clock
// MULT_BOOTH_UNSIGNED_EN enables MULTU (is_unsigned) support with one extra step.
module mult_booth_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input logic             clk,
   input logic             reset,
   mult_booth_seq_if.slave bus
);
   localparam int E = ext_width(WIDTH);
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [E-1:0] m_q, m_d;
   logic [2*E:0] p_q, p_d, p_next;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic busy_q, busy_d, done_q, done_d;
   logic sx, go, last;
   logic [E-1:0] ext_a, ext_b;
`ifdef MULT_BOOTH_UNSIGNED_EN
   assign sx = !bus.is_unsigned;
`else
   assign sx = 1'b1;
`endif
   assign ext_a = sx ? E'($signed(bus.a)) : E'(bus.a);
   assign ext_b = sx ? E'($signed(bus.b)) : E'(bus.b);
   booth_step #(.E(E)) u_step (.p(p_q), .m(m_q), .p_next(p_next));
   always_comb begin
      go = bus.start && state_q != RUN;
      last = state_q == RUN && cnt_q == CNT_W'(E - 1);
      state_d = go ? RUN : state_q == RUN ? (last ? DONE : RUN) : IDLE;
      cnt_d = go ? '0 : state_q == RUN ? cnt_q + 1'b1 : cnt_q;
      m_d = go ? ext_a : m_q;
      p_d = go ? {{E{1'b0}}, ext_b, 1'b0} : state_q == RUN ? p_next : p_q;
      hi_d = last ? p_next[2*WIDTH:WIDTH+1] : hi_q;
      lo_d = last ? p_next[WIDTH:1] : lo_q;
      busy_d = state_d == RUN;
      done_d = state_d == DONE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         m_q <= '0;
         p_q <= '0;
         hi_q <= '0;
         lo_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         m_q <= m_d;
         p_q <= p_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi = hi_q;
   assign bus.lo = lo_q;
endmodule

// File: tb/tb_mult_booth_seq.sv
// tb_mult_booth_seq: table-driven directed checks plus restart, back-to-back and async-reset sequences
module tb_mult_booth_seq;
`ifdef MULT_BOOTH_UNSIGNED_EN
   localparam int N = 33;
`else
   localparam int N = 32;
`endif
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        uns;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int errors = 0;
   int checks = 0;
   mult_booth_seq_if #(.WIDTH(32)) bus ();
   mult_booth_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string name, input vec_t v);
      int lat;
      bus.start = 1'b1;
      bus.a = v.a;
      bus.b = v.b;
      bus.is_unsigned = v.uns;
      @(negedge clk);
      check({name, " busy"}, 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      bus.a = 32'hDEADBEEF;
      bus.b = 32'h0BADF00D;
      bus.is_unsigned = ~v.uns;
      wait_done(lat);
      check({name, " latency"}, 64'(lat), 64'(N));
      check({name, " hi"}, 64'(bus.hi), 64'(v.hi));
      check({name, " lo"}, 64'(bus.lo), 64'(v.lo));
      check({name, " busy at done"}, 64'(bus.busy), 64'd0);
      @(negedge clk);
      check({name, " done pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      vec_t vecs[$];
      int lat;
      int n_done;
      vecs.push_back('{32'd7, 32'd6, 1'b0, 32'h00000000, 32'h0000002A});
      vecs.push_back('{32'hFFFFFFFD, 32'd5, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1});
      vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000});
      vecs.push_back('{32'h00000000, 32'h12345678, 1'b0, 32'h00000000, 32'h00000000});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001});
      vecs.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h3FFFFFFF, 32'h00000001});
      vecs.push_back('{32'h80000000, 32'd1, 1'b0, 32'hFFFFFFFF, 32'h80000000});
      vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b0, 32'hC0000000, 32'h80000000});
      vecs.push_back('{32'd12345, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFF, 32'hFFFF9F8E});
`ifdef MULT_BOOTH_UNSIGNED_EN
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001});
      vecs.push_back('{32'h80000000, 32'd2, 1'b1, 32'h00000001, 32'h00000000});
`else
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001});
      vecs.push_back('{32'h80000000, 32'd2, 1'b1, 32'hFFFFFFFF, 32'h00000000});
`endif
      bus.start = 1'b0;
      bus.is_unsigned = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (2) @(negedge clk);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset hi", 64'(bus.hi), 64'd0);
      check("reset lo", 64'(bus.lo), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);
      // start mid-RUN with other operands must be ignored
      bus.start = 1'b1;
      bus.a = 32'd7;
      bus.b = 32'd6;
      bus.is_unsigned = 1'b0;
      @(negedge clk);
      lat = 0;
      while (!bus.done && lat < 100) begin
         bus.start = lat == 5;
         bus.a = 32'd100;
         bus.b = 32'd100;
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      check("restart latency", 64'(lat), 64'(N));
      check("restart hi", 64'(bus.hi), 64'd0);
      check("restart lo", 64'(bus.lo), 64'd42);
      n_done = 0;
      repeat (N + 4) begin
         @(negedge clk);
         n_done += int'(bus.done);
      end
      check("restart extra done", 64'(n_done), 64'd0);
      check("restart idle busy", 64'(bus.busy), 64'd0);
      // start held through the DONE cycle chains a second operation
      bus.start = 1'b1;
      bus.a = 32'd9;
      bus.b = 32'd11;
      @(negedge clk);
      wait_done(lat);
      bus.a = 32'hFFFFFFFD;
      bus.b = 32'd5;
      check("b2b first latency", 64'(lat), 64'(N));
      check("b2b first lo", 64'(bus.lo), 64'd99);
      @(negedge clk);
      check("b2b done width", 64'(bus.done), 64'd0);
      check("b2b busy", 64'(bus.busy), 64'd1);
      bus.start = 1'b0;
      wait_done(lat);
      check("b2b second latency", 64'(lat), 64'(N));
      check("b2b second hi", 64'(bus.hi), 64'hFFFFFFFF);
      check("b2b second lo", 64'(bus.lo), 64'hFFFFFFF1);
      @(negedge clk);
      // asynchronous reset in the middle of an operation
      bus.start = 1'b1;
      bus.a = 32'h12345678;
      bus.b = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("areset busy", 64'(bus.busy), 64'd0);
      check("areset done", 64'(bus.done), 64'd0);
      check("areset hi", 64'(bus.hi), 64'd0);
      check("areset lo", 64'(bus.lo), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      n_done = 0;
      repeat (N + 4) begin
         @(negedge clk);
         n_done += int'(bus.done | bus.busy);
      end
      check("areset no done", 64'(n_done), 64'd0);
      run_op("after reset", '{32'd2, 32'd3, 1'b0, 32'h0, 32'h6});
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
